// File: rtl/scan_chain_ctrl.sv
// Scan-chain test sequencer: shifts a pattern into the chain, runs functional capture,
// unloads the chain through its registered output and checks the result under a mask.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN  = 8,
   parameter int OUT_LAT    = 1,
   parameter int CAP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic [CHAIN_LEN-1:0] expected,
   input  logic [CHAIN_LEN-1:0] mask,
   input  logic                 func_d_val,
   input  logic                 scan_out,
   output logic                 scan_en,
   output logic                 scan_in,
   output logic                 func_d,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CHAIN_LEN-1:0] captured,
   output logic [7:0]           fail_count
);
   localparam int UNL_EDGES = CHAIN_LEN + OUT_LAT;
   localparam int CNT_MAX   = (UNL_EDGES > CAP_CYCLES) ? UNL_EDGES : CAP_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(CAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] UNL_LAST  = CNT_W'(UNL_EDGES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      CAPTURE = 3'd2,
      UNLOAD  = 3'd3,
      CHECK   = 3'd4
   } stateT;

   stateT                state, nextState;
   logic [CNT_W-1:0]     cnt, nextCnt;
   logic [CHAIN_LEN-1:0] loadSh, nextLoadSh;
   logic [CHAIN_LEN-1:0] unloadSh, nextUnloadSh;
   logic [CHAIN_LEN-1:0] expR, nextExp;
   logic [CHAIN_LEN-1:0] maskR, nextMask;
   logic                 fdvR, nextFdv;
   logic                 nextScanEn, nextScanIn, nextFuncD, nextBusy, nextDone, nextPass;
   logic [CHAIN_LEN-1:0] nextCaptured;
   logic [7:0]           nextFailCount;
   logic                 runFails;

   // Next-state and next-output logic; outputs are computed one cycle ahead so the
   // chain sees each value at the edge after it is registered.
   always_comb begin
      nextState     = state;
      nextCnt       = cnt;
      nextLoadSh    = loadSh;
      nextUnloadSh  = unloadSh;
      nextExp       = expR;
      nextMask      = maskR;
      nextFdv       = fdvR;
      nextScanEn    = scan_en;
      nextScanIn    = scan_in;
      nextFuncD     = func_d;
      nextBusy      = busy;
      nextDone      = 1'b0;
      nextPass      = pass;
      nextCaptured  = captured;
      nextFailCount = fail_count;
      runFails      = 1'b0;
      case (state)
         // CHECK has busy low, so a start there chains the next run without a gap.
         IDLE, CHECK: begin
            nextScanEn = 1'b0;
            nextScanIn = 1'b0;
            nextFuncD  = 1'b0;
            nextBusy   = 1'b0;
            if (start) begin
               nextState  = LOAD;
               nextCnt    = '0;
               nextScanEn = 1'b1;
               nextScanIn = pattern[CHAIN_LEN-1];
               nextLoadSh = {pattern[CHAIN_LEN-2:0], 1'b0};
               nextExp    = expected;
               nextMask   = mask;
               nextFdv    = func_d_val;
               nextBusy   = 1'b1;
            end else begin
               nextState = IDLE;
            end
         end
         LOAD: begin
            if (cnt == LOAD_LAST) begin
               nextState  = CAPTURE;
               nextCnt    = '0;
               nextScanEn = 1'b0;
               nextScanIn = 1'b0;
               nextFuncD  = fdvR;
            end else begin
               nextCnt    = cnt + CNT_W'(1);
               nextScanIn = loadSh[CHAIN_LEN-1];
               nextLoadSh = {loadSh[CHAIN_LEN-2:0], 1'b0};
            end
         end
         CAPTURE: begin
            if (cnt == CAP_LAST) begin
               nextState  = UNLOAD;
               nextCnt    = '0;
               nextScanEn = 1'b1;
               nextScanIn = 1'b0;
               nextFuncD  = 1'b0;
            end else begin
               nextCnt = cnt + CNT_W'(1);
            end
         end
         UNLOAD: begin
            // Stale output-register samples simply fall off the top of the shifter.
            nextUnloadSh = {unloadSh[CHAIN_LEN-2:0], scan_out};
            if (cnt == UNL_LAST) begin
               nextState    = CHECK;
               nextCnt      = '0;
               nextScanEn   = 1'b0;
               nextBusy     = 1'b0;
               nextDone     = 1'b1;
               nextCaptured = nextUnloadSh;
               runFails     = (((nextUnloadSh ^ expR) & maskR) != '0);
               nextPass     = ~runFails;
               if (runFails && (fail_count != 8'hFF)) begin
                  nextFailCount = fail_count + 8'd1;
               end else begin
                  nextFailCount = fail_count;
               end
            end else begin
               nextCnt = cnt + CNT_W'(1);
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State and registered-output update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         loadSh     <= '0;
         unloadSh   <= '0;
         expR       <= '0;
         maskR      <= '0;
         fdvR       <= 1'b0;
         scan_en    <= 1'b0;
         scan_in    <= 1'b0;
         func_d     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         captured   <= '0;
         fail_count <= 8'd0;
      end else begin
         state      <= nextState;
         cnt        <= nextCnt;
         loadSh     <= nextLoadSh;
         unloadSh   <= nextUnloadSh;
         expR       <= nextExp;
         maskR      <= nextMask;
         fdvR       <= nextFdv;
         scan_en    <= nextScanEn;
         scan_in    <= nextScanIn;
         func_d     <= nextFuncD;
         busy       <= nextBusy;
         done       <= nextDone;
         pass       <= nextPass;
         captured   <= nextCaptured;
         fail_count <= nextFailCount;
      end
   end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl: models the 8-stage chain with a registered
// serial output and compares the sequencer against a word-level reference model.
module tb_scan_chain_ctrl;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n, start, func_d_val;
   logic         scan_out = 1'b0;
   logic [N-1:0] pattern, expected, mask;
   logic         scan_en, scan_in, func_d, busy, done, pass;
   logic [N-1:0] captured;
   logic [7:0]   fail_count;
   logic [N-1:0] chain = '0;

   int nVec = 0;
   int nBad = 0;
   int modelFails = 0;
   logic recEn [0:63];
   logic recIn [0:63];
   logic recFd [0:63];
   logic recBusy [0:63];
   logic recDone [0:63];

   always #5 clk = ~clk;

   scan_chain_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .expected(expected),
      .mask(mask), .func_d_val(func_d_val), .scan_out(scan_out), .scan_en(scan_en),
      .scan_in(scan_in), .func_d(func_d), .busy(busy), .done(done), .pass(pass),
      .captured(captured), .fail_count(fail_count)
   );

   // Chain model: shift in scan mode, inverting functional path otherwise, registered tap.
   always @(posedge clk) begin
      if (scan_en) chain <= {chain[N-2:0], scan_in};
      else         chain <= {~chain[N-2:0], func_d};
      scan_out <= chain[N-1];
   end

   function automatic logic [N-1:0] modelCap(input logic [N-1:0] p, input logic fdv);
      return {~p[N-2:0], fdv};
   endfunction

   function automatic logic modelPass(input logic [N-1:0] c, e, m);
      return ((c ^ e) & m) == '0;
   endfunction

   function automatic void modelUpdate(input logic ok);
      if (!ok && modelFails < 255) modelFails = modelFails + 1;
   endfunction

   // Drives one run from the current negedge; records the chain pins per cycle.
   task automatic runOne(input logic [N-1:0] p, e, m, input logic fdv,
                         input bit hold, input bit scramble, output int doneCyc);
      pattern = p; expected = e; mask = m; func_d_val = fdv; start = 1'b1;
      @(posedge clk);
      doneCyc = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         if (scramble && c == 5) begin
            pattern = 8'($urandom); expected = 8'($urandom);
            mask = 8'($urandom); func_d_val = 1'($urandom);
         end
         recEn[c] = scan_en; recIn[c] = scan_in; recFd[c] = func_d;
         recBusy[c] = busy; recDone[c] = done;
         if (done) begin
            doneCyc = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; pattern = '0; expected = '0; mask = '0; func_d_val = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nVec++;
      if ({scan_en, scan_in, func_d, busy, done, pass, captured, fail_count} !== 21'd0) begin
         nBad++;
         $display("FAIL reset_state: got en=%b in=%b fd=%b busy=%b done=%b pass=%b cap=%h fc=%0d, want all zero",
                  scan_en, scan_in, func_d, busy, done, pass, captured, fail_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
      modelFails = 0;
   endtask

   task automatic test_single();
      int dc;
      runOne(8'hA5, 8'hB5, 8'hFF, 1'b1, 1'b0, 1'b0, dc);
      modelUpdate(1'b1);
      nVec++; if (dc !== 19) begin nBad++; $display("FAIL single_latency: got %0d want 19", dc); end
      nVec++; if (captured !== 8'hB5) begin nBad++; $display("FAIL single_captured: got %h want b5", captured); end
      nVec++; if (pass !== 1'b1) begin nBad++; $display("FAIL single_pass: got %b want 1", pass); end
      nVec++; if (fail_count !== 8'd0) begin nBad++; $display("FAIL single_failcount: got %0d want 0", fail_count); end
   endtask

   task automatic test_failing();
      int dc;
      runOne(8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, dc);
      modelUpdate(1'b0);
      nVec++; if (captured !== 8'hFE) begin nBad++; $display("FAIL fail_captured: got %h want fe", captured); end
      nVec++; if (pass !== 1'b0) begin nBad++; $display("FAIL fail_pass: got %b want 0", pass); end
      nVec++; if (fail_count !== 8'(modelFails)) begin nBad++; $display("FAIL fail_count: got %0d want %0d", fail_count, modelFails); end
      runOne(8'h00, 8'hFF, 8'hFE, 1'b0, 1'b0, 1'b0, dc);
      nVec++; if (pass !== 1'b1) begin nBad++; $display("FAIL masked_pass: got %b want 1", pass); end
      nVec++; if (fail_count !== 8'(modelFails)) begin nBad++; $display("FAIL masked_failcount: got %0d want %0d", fail_count, modelFails); end
      runOne(8'h3C, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, dc);
      nVec++; if (pass !== 1'b1) begin nBad++; $display("FAIL zero_mask_pass: got %b want 1", pass); end
   endtask

   task automatic test_protocol();
      int dc;
      logic [N-1:0] p, e, m, c;
      logic fdv;
      logic [4:0] want, got;
      for (int r = 0; r < 6; r++) begin
         p = 8'($urandom); e = 8'($urandom); m = 8'($urandom); fdv = 1'($urandom);
         runOne(p, e, m, fdv, 1'b0, 1'b0, dc);
         c = modelCap(p, fdv);
         modelUpdate(modelPass(c, e, m));
         nVec++; if (dc !== 19) begin nBad++; $display("FAIL proto_latency: got %0d want 19", dc); end
         nVec++; if (captured !== c) begin nBad++; $display("FAIL proto_captured: got %h want %h", captured, c); end
         nVec++; if (pass !== modelPass(c, e, m)) begin nBad++; $display("FAIL proto_pass: got %b want %b", pass, modelPass(c, e, m)); end
         if (dc == 19) begin
            for (int k = 1; k <= 19; k++) begin
               want[4] = (k <= N) || (k >= N + 2 && k <= 2 * N + 2);
               want[3] = (k <= N) ? p[N - k] : 1'b0;
               want[2] = (k == N + 1) ? fdv : 1'b0;
               want[1] = (k <= 18);
               want[0] = (k == 19);
               got = {recEn[k], recIn[k], recFd[k], recBusy[k], recDone[k]};
               nVec++;
               if (got !== want) begin
                  nBad++;
                  $display("FAIL proto_pins cycle %0d: got en/in/fd/busy/done=%b want %b", k, got, want);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int dc;
      logic [N-1:0] p, e, m, c;
      logic fdv;
      for (int r = 0; r < 4; r++) begin
         p = 8'($urandom); e = 8'($urandom); m = 8'($urandom); fdv = 1'($urandom);
         runOne(p, e, m, fdv, 1'b1, 1'b1, dc);
         c = modelCap(p, fdv);
         modelUpdate(modelPass(c, e, m));
         nVec++; if (dc !== 19) begin nBad++; $display("FAIL b2b_latency run %0d: got %0d want 19", r, dc); end
         nVec++; if (captured !== c) begin nBad++; $display("FAIL b2b_captured run %0d: got %h want %h", r, captured, c); end
         nVec++; if (fail_count !== 8'(modelFails)) begin nBad++; $display("FAIL b2b_failcount: got %0d want %0d", fail_count, modelFails); end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_saturation();
      int dc;
      logic [N-1:0] p, e, c;
      logic fdv;
      for (int r = 0; r < 260; r++) begin
         p = 8'($urandom); fdv = 1'($urandom);
         c = modelCap(p, fdv);
         e = c ^ 8'($urandom_range(1, 255));
         runOne(p, e, 8'hFF, fdv, 1'b0, 1'b0, dc);
         modelUpdate(1'b0);
         nVec++; if (pass !== 1'b0) begin nBad++; $display("FAIL sat_pass run %0d: got %b want 0", r, pass); end
         nVec++; if (fail_count !== 8'(modelFails)) begin nBad++; $display("FAIL sat_count run %0d: got %0d want %0d", r, fail_count, modelFails); end
      end
      nVec++; if (fail_count !== 8'd255) begin nBad++; $display("FAIL sat_final: got %0d want 255", fail_count); end
   endtask

   task automatic test_reset_midrun();
      int dc, k;
      bit sawDone;
      logic [N-1:0] p, e, c;
      logic fdv;
      for (int s = 0; s < 2; s++) begin
         k = (s == 0) ? int'($urandom_range(1, 17)) : int'($urandom_range(10, 17));
         pattern = 8'($urandom); expected = 8'($urandom); mask = 8'hFF; func_d_val = 1'($urandom);
         start = 1'b1;
         @(posedge clk);
         start = 1'b0;
         repeat (k) @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         nVec++;
         if ({scan_en, scan_in, func_d, busy, done, pass, captured, fail_count} !== 21'd0) begin
            nBad++;
            $display("FAIL midrun_reset_state at cycle %0d: got en=%b in=%b fd=%b busy=%b done=%b pass=%b cap=%h fc=%0d",
                     k, scan_en, scan_in, func_d, busy, done, pass, captured, fail_count);
         end
         rst_n = 1'b1;
         modelFails = 0;
         sawDone = 1'b0;
         repeat (25) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
         end
         nVec++; if (sawDone) begin nBad++; $display("FAIL midrun_no_done: got done pulse, want none"); end
         p = 8'($urandom); fdv = 1'($urandom); e = 8'($urandom);
         runOne(p, e, 8'hFF, fdv, 1'b0, 1'b0, dc);
         c = modelCap(p, fdv);
         modelUpdate(modelPass(c, e, 8'hFF));
         nVec++; if (dc !== 19) begin nBad++; $display("FAIL post_reset_latency: got %0d want 19", dc); end
         nVec++; if (captured !== c) begin nBad++; $display("FAIL post_reset_captured: got %h want %h", captured, c); end
         nVec++; if (fail_count !== 8'(modelFails)) begin nBad++; $display("FAIL post_reset_failcount: got %0d want %0d", fail_count, modelFails); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_failing();
      test_protocol();
      test_back_to_back();
      test_saturation();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end
endmodule
